// File: rtl/accel_ctrl_pkg.sv
// Shared types and constants for the program sequencer.
package accel_ctrl_pkg;

  localparam int unsigned DrainCyclesDefault = 3;

  typedef enum logic [2:0] {
    StIdle,
    StBoot,
    StRun,
    StDrain,
    StDone
  } seq_state_e;

endpackage

// File: rtl/hw_loop_unit.sv
// Zero-overhead hardware loop: redirects fetch from loop_end back to loop_start
// a configured number of times. Only instantiated when HW_LOOP_EN is defined.
module hw_loop_unit
  import accel_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_end,
  input  logic [7:0]            cfg_iters,
  input  logic                  active,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  take,
  output logic [ADDR_WIDTH-1:0] target
);

  logic [ADDR_WIDTH-1:0] start_q;
  logic [ADDR_WIDTH-1:0] end_q;
  logic [7:0]            remaining_q;

  assign take   = active && (pc == end_q) && (remaining_q != 8'd0);
  assign target = start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q     <= '0;
      end_q       <= '0;
      remaining_q <= 8'd0;
    end else if (load) begin
      start_q     <= cfg_start;
      end_q       <= cfg_end;
      remaining_q <= cfg_iters;
    end else if (take) begin
      remaining_q <= remaining_q - 8'd1;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: boots fetch at entry_pc, steers redirects while running,
// drains the pipeline after halt. Define HW_LOOP_EN to add the hardware loop.
module program_sequencer
  import accel_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DRAIN_CYCLES = DrainCyclesDefault
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] entry_pc,
  input  logic                  abort,
  input  logic                  stall_req,
  input  logic                  halt,
  input  logic                  jr_req,
  input  logic [ADDR_WIDTH-1:0] jr_target,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] loop_start,
  input  logic [ADDR_WIDTH-1:0] loop_end,
  input  logic [7:0]            loop_iters,
  output logic                  fetch_en,
  output logic                  jump_reg,
  output logic [ADDR_WIDTH-1:0] jr_pc,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           cycle_count
);

  localparam logic [3:0] DrainLast = 4'(DRAIN_CYCLES - 1);

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] entry_q;
  logic [3:0]            drain_q;
  logic [31:0]           cycle_count_q;
  logic                  start_ok;
  logic                  loop_active;
  logic                  loop_take;
  logic [ADDR_WIDTH-1:0] loop_target;

  assign start_ok    = (state_q == StIdle) && start && !abort;
  // The loop may only fire on a fetching RUN cycle that no jr_req pre-empts.
  assign loop_active = (state_q == StRun) && !abort && !stall_req && !jr_req;

`ifdef HW_LOOP_EN
  hw_loop_unit #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_hw_loop (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_ok),
    .cfg_start(loop_start),
    .cfg_end  (loop_end),
    .cfg_iters(loop_iters),
    .active   (loop_active),
    .pc       (pc),
    .take     (loop_take),
    .target   (loop_target)
  );
`else
  logic unused_loop;
  assign unused_loop = ^{loop_start, loop_end, loop_iters, pc, loop_active};
  assign loop_take   = 1'b0;
  assign loop_target = '0;
`endif

  always_comb begin
    state_d  = state_q;
    fetch_en = 1'b0;
    jump_reg = 1'b0;
    jr_pc    = '0;
    unique case (state_q)
      StIdle: begin
        if (start_ok) state_d = StBoot;
      end
      StBoot: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          fetch_en = 1'b1;
          jump_reg = 1'b1;
          jr_pc    = entry_q;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          fetch_en = !stall_req;
          if (!stall_req) begin
            if (jr_req) begin
              jump_reg = 1'b1;
              jr_pc    = jr_target;
            end else if (loop_take) begin
              jump_reg = 1'b1;
              jr_pc    = loop_target;
            end
            if (halt) state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          fetch_en = 1'b1;
          if (drain_q == 4'd0) state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy        = (state_q == StBoot) || (state_q == StRun) || (state_q == StDrain);
  assign done        = (state_q == StDone);
  assign cycle_count = cycle_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      entry_q <= '0;
      drain_q <= 4'd0;
    end else begin
      state_q <= state_d;
      if (start_ok) entry_q <= entry_pc;
      if ((state_q == StRun) && (state_d == StDrain)) begin
        drain_q <= DrainLast;
      end else if ((state_q == StDrain) && (drain_q != 4'd0)) begin
        drain_q <= drain_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count_q <= 32'd0;
    end else if (start_ok) begin
      cycle_count_q <= 32'd0;
    end else if ((state_q == StRun || state_q == StDrain) && (cycle_count_q != 32'hFFFF_FFFF)) begin
      cycle_count_q <= cycle_count_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: a behavioural model predicts each cycle's
// outputs into a queue, a negedge monitor pops and compares against the DUT.
module tb_program_sequencer;

  localparam int AW = 8;
  localparam int DC = 3;

  localparam int MIdle  = 0;
  localparam int MBoot  = 1;
  localparam int MRun   = 2;
  localparam int MDrain = 3;
  localparam int MDone  = 4;

  typedef struct packed {
    logic          fe;
    logic          jr;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic [31:0]   cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start, abort, stall_req, halt, jr_req;
  logic [AW-1:0] entry_pc, jr_target, pc, loop_start, loop_end;
  logic [7:0]    loop_iters;
  logic          fetch_en, jump_reg, busy, done;
  logic [AW-1:0] jr_pc;
  logic [31:0]   cycle_count;

  int n_total = 0;
  int n_pass  = 0;

  exp_t        exp_q[$];
  logic [31:0] done_q[$];

  // Reference model state
  int          m_state = MIdle;
  logic [AW-1:0] m_entry, m_ls, m_le;
  int          m_rem, m_left;
  longint      m_cnt = 0;

  always #5 clk = ~clk;

  program_sequencer #(
    .ADDR_WIDTH  (AW),
    .DRAIN_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .entry_pc   (entry_pc),
    .abort      (abort),
    .stall_req  (stall_req),
    .halt       (halt),
    .jr_req     (jr_req),
    .jr_target  (jr_target),
    .pc         (pc),
    .loop_start (loop_start),
    .loop_end   (loop_end),
    .loop_iters (loop_iters),
    .fetch_en   (fetch_en),
    .jump_reg   (jump_reg),
    .jr_pc      (jr_pc),
    .busy       (busy),
    .done       (done),
    .cycle_count(cycle_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  task automatic model_reset();
    m_state = MIdle;
    m_entry = '0;
    m_ls    = '0;
    m_le    = '0;
    m_rem   = 0;
    m_left  = 0;
    m_cnt   = 0;
  endtask

  task automatic bump();
    if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
  endtask

  task automatic model_cycle(output exp_t e);
    int nxt;
    e     = '0;
    e.cnt = m_cnt[31:0];
    nxt   = m_state;
    case (m_state)
      MIdle: if (start && !abort) begin
        nxt     = MBoot;
        m_entry = entry_pc;
        m_ls    = loop_start;
        m_le    = loop_end;
`ifdef HW_LOOP_EN
        m_rem   = int'(loop_iters);
`else
        m_rem   = 0;
`endif
        m_cnt   = 0;
      end
      MBoot: begin
        e.busy = 1'b1;
        if (abort) nxt = MIdle;
        else begin
          e.fe = 1'b1; e.jr = 1'b1; e.pc = m_entry; nxt = MRun;
        end
      end
      MRun: begin
        e.busy = 1'b1;
        bump();
        if (abort) nxt = MIdle;
        else begin
          e.fe = !stall_req;
          if (e.fe && jr_req) begin
            e.jr = 1'b1; e.pc = jr_target;
          end else if (e.fe && pc == m_le && m_rem > 0) begin
            e.jr = 1'b1; e.pc = m_ls; m_rem--;
          end
          if (halt && !stall_req) begin
            nxt = MDrain; m_left = DC;
          end
        end
      end
      MDrain: begin
        e.busy = 1'b1;
        bump();
        if (abort) nxt = MIdle;
        else begin
          e.fe = 1'b1;
          m_left--;
          if (m_left == 0) nxt = MDone;
        end
      end
      default: begin
        e.done = 1'b1;
        done_q.push_back(m_cnt[31:0]);
        nxt = MIdle;
      end
    endcase
    m_state = nxt;
  endtask

  // Predict this cycle, then emulate the fetch unit's pc update and move to next cycle.
  task automatic tick();
    exp_t e;
    model_cycle(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (e.jr) pc = e.pc;
    else if (e.fe) pc = pc + 1'b1;
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; stall_req = 0; halt = 0; jr_req = 0; jr_target = '0;
  endtask

  task automatic do_start(input logic [AW-1:0] ep, input logic [AW-1:0] ls,
                          input logic [AW-1:0] le, input logic [7:0] it);
    idle_inputs();
    start = 1; entry_pc = ep; loop_start = ls; loop_end = le; loop_iters = it;
    tick();
    start = 0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_outs"}, {fetch_en, jump_reg, jr_pc, busy, done}, '0);
    check({name, "_cnt"}, cycle_count, 0);
  endtask

  // Monitor: compares each predicted cycle; checks run time whenever done pulses.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle_outs", {fetch_en, jump_reg, jr_pc, busy, done, cycle_count}, e);
    end
    if (done === 1'b1) begin
      if (done_q.size() > 0) check("done_count", cycle_count, done_q.pop_front());
      else check("unexpected_done", done, 1'b0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    entry_pc = '0; pc = '0; loop_start = '0; loop_end = '0; loop_iters = '0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1;
    repeat (2) tick();

    // Basic run: halt on the sixth RUN cycle.
    do_start(8'h10, 8'h00, 8'h00, 8'd0);
    tick();
    repeat (5) tick();
    halt = 1; tick(); halt = 0;
    repeat (DC + 1) tick();
    check("basic_count", cycle_count, 9);

    // Stall with jr_req pending, redirect only once fetch resumes.
    do_start(8'h30, 8'h00, 8'h00, 8'd0);
    tick(); tick();
    stall_req = 1; jr_req = 1; jr_target = 8'h40;
    repeat (2) begin
      #1 check("stall_nojump", {fetch_en, jump_reg, jr_pc}, '0);
      tick();
    end
    stall_req = 0;
    #1 check("jr_redirect", {fetch_en, jump_reg, jr_pc}, {2'b11, 8'h40});
    tick();
    jr_req = 0; halt = 1; tick(); halt = 0;
    repeat (DC + 2) tick();

`ifdef HW_LOOP_EN
    // Two loop-backs to 0x04 then fall through past 0x07.
    do_start(8'h00, 8'h04, 8'h07, 8'd2);
    repeat (22) tick();
    check("loop_fallthrough_pc", pc > 8'h07, 1'b1);
    halt = 1; tick(); halt = 0;
    repeat (DC + 2) tick();

    // jr_req at loop_end overrides the loop.
    do_start(8'h00, 8'h04, 8'h07, 8'd2);
    tick();
    for (int i = 0; i < 12; i++) begin
      jr_req = (pc == 8'h07); jr_target = 8'h20;
      if (jr_req) #1 check("jr_over_loop", {jump_reg, jr_pc}, {1'b1, 8'h20});
      tick();
      jr_req = 0;
    end
    halt = 1; tick(); halt = 0;
    repeat (DC + 2) tick();
`endif

    // Start while busy is ignored, abort in DRAIN returns to IDLE without done.
    do_start(8'h20, 8'h00, 8'h00, 8'd0);
    tick(); tick();
    start = 1; tick(); start = 0;
    tick();
    halt = 1; tick(); halt = 0;
    tick();
    abort = 1;
    #1 check("abort_fetch_off", fetch_en, 1'b0);
    tick();
    abort = 0;
    check("abort_idle", {busy, done}, 2'b00);
    check("abort_count", cycle_count, 6);
    start = 1; abort = 1; tick(); idle_inputs();
    check("start_abort_idle", busy, 1'b0);
    tick();

    // Async reset between clock edges mid-RUN.
    do_start(8'h50, 8'h00, 8'h00, 8'd0);
    tick(); tick(); tick();
    #2 rst_n = 0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    do_start(8'h18, 8'h00, 8'h00, 8'd0);
    tick(); repeat (3) tick();
    halt = 1; tick(); halt = 0;
    repeat (DC + 2) tick();

    // Saturation of the run-time counter.
    do_start(8'h00, 8'h00, 8'h00, 8'd0);
    tick(); tick();
    force dut.cycle_count_q = 32'hFFFF_FFFE;
    #1 release dut.cycle_count_q;
    m_cnt = 64'hFFFF_FFFE;
    repeat (3) tick();
    check("saturate", cycle_count, 32'hFFFF_FFFF);
    abort = 1; tick(); abort = 0; tick();

    // Randomised programs.
    for (int p = 0; p < 25; p++) begin
      logic [AW-1:0] ls;
      ls = AW'($urandom_range(0, 12));
      do_start(AW'($urandom_range(0, 8)), ls, ls + AW'($urandom_range(0, 6)),
               8'($urandom_range(0, 3)));
      for (int c = 0; c < 60 && m_state != MIdle; c++) begin
        stall_req = ($urandom_range(0, 3) == 0);
        jr_req    = ($urandom_range(0, 9) == 0);
        jr_target = AW'($urandom_range(0, 20));
        halt      = (c > 8) && ($urandom_range(0, 5) == 0);
        abort     = ($urandom_range(0, 40) == 0);
        start     = ($urandom_range(0, 10) == 0);
        tick();
      end
      idle_inputs();
      abort = 1; tick(); abort = 0;
      tick();
    end

    @(negedge clk); #1;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, instruction address width.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, pipeline flush cycles after halt (range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin program; honoured only in IDLE.
REQ-006 SHALL have port entry_pc  input  ADDR_WIDTH  first instruction address, sampled with start.
REQ-007 SHALL have port abort  input  1  synchronous kill of the running program.
REQ-008 SHALL have port stall_req  input  1  hazard stall from decode/execute.
REQ-009 SHALL have port halt  input  1  decoded halt instruction.
REQ-010 SHALL have port jr_req  input  1  decoded jump-register request.
REQ-011 SHALL have port jr_target  input  ADDR_WIDTH  jump-register destination.
REQ-012 SHALL have port pc  input  ADDR_WIDTH  current pc from instruction fetch.
REQ-013 SHALL have ports loop_start, loop_end  input  ADDR_WIDTH each, and loop_iters  input  8  hardware-loop configuration, sampled with start.
REQ-014 SHALL have port fetch_en  output  1  instruction-fetch enable.
REQ-015 SHALL have port jump_reg  output  1  redirect fetch this cycle.
REQ-016 SHALL have port jr_pc  output  ADDR_WIDTH  redirect address.
REQ-017 SHALL have ports busy  output  1 and done  output  1 (one-cycle pulse).
REQ-018 SHALL have port cycle_count  output  32  run-time counter.

Function
REQ-019 SHALL implement states IDLE, BOOT, RUN, DRAIN, DONE.
REQ-020 IDLE: fetch_en=0, jump_reg=0; start=1 -> BOOT, latching entry_pc and loop configuration.
REQ-021 BOOT (1 cycle): fetch_en=1, jump_reg=1, jr_pc=latched entry_pc; -> RUN.
REQ-022 RUN: fetch_en = ~stall_req; jump_reg asserted only when fetch_en=1.
REQ-023 RUN redirect priority: jr_req (jr_pc=jr_target) over hardware loop (REQ-033) over sequential (jump_reg=0).
REQ-024 RUN: halt=1 with stall_req=0 -> DRAIN; halt during stall_req=1 ignored until stall clears.
REQ-025 DRAIN: fetch_en=1, jump_reg=0 for exactly DRAIN_CYCLES cycles, then -> DONE; stall_req, jr_req, halt ignored.
REQ-026 DONE (1 cycle): done=1, fetch_en=0; -> IDLE.
REQ-027 busy=1 in BOOT, RUN, DRAIN; 0 in IDLE, DONE.
REQ-028 start outside IDLE ignored; start and abort together in IDLE: abort wins, stay IDLE.
REQ-029 abort=1 in BOOT/RUN/DRAIN -> IDLE next cycle, no done pulse, fetch_en=0 that cycle.
REQ-030 cycle_count cleared on accepted start; increments every RUN and DRAIN cycle (stalls included); saturates at 0xFFFF_FFFF; holds value in IDLE until next start.
REQ-031 jr_pc SHALL be 0 whenever jump_reg=0.

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, fetch_en=0, jump_reg=0, jr_pc=0, busy=0, done=0, cycle_count=0, loop counter 0, latched addresses 0; mid-run reset abandons program without done.

Configuration
REQ-033 With HW_LOOP_EN defined: in RUN, when fetch_en=1, jr_req=0, pc==loop_end and remaining>0: jump_reg=1, jr_pc=loop_start, remaining decrements; remaining loaded from loop_iters at start; loop_iters=0 disables looping; remaining=0 at pc==loop_end falls through.
REQ-034 Without HW_LOOP_EN: loop ports SHALL remain present but be ignored; no loop counter registers synthesized.

Structure
REQ-035 Shared package accel_ctrl_pkg SHALL hold the state enum typedef and the DRAIN_CYCLES default constant.
REQ-036 Hardware-loop logic SHALL be sub-module hw_loop_unit, instantiated only under HW_LOOP_EN.

Verification
REQ-037 Basic run: start, entry_pc=0x10, halt 6 cycles after BOOT -> BOOT redirect to 0x10, fetch_en high in RUN, 3 DRAIN cycles, done pulse, cycle_count=9.
REQ-038 Stall/jump: stall_req 2 cycles then jr_req with jr_target=0x40 -> fetch_en=0 for 2 cycles, jump_reg=1 jr_pc=0x40 only when fetch_en=1.
REQ-039 HW loop (HW_LOOP_EN): loop_start=0x04, loop_end=0x07, loop_iters=2 -> exactly two redirects to 0x04, then falls through past 0x07; jr_req at pc=0x07 overrides loop.
REQ-040 Abort in DRAIN and start while busy -> IDLE next cycle, no done; mid-run start ignored, cycle_count uncleared.
REQ-041 Async reset asserted mid-RUN between clock edges -> all outputs 0 immediately; start after release runs normally.
REQ-042 Saturation: force cycle_count to 0xFFFF_FFFE, run 3 cycles -> stays 0xFFFF_FFFF.
